// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported instruction/data memory between the IF-stage
//   fetch and the MEM/WB-stage load/store. Each access runs as a req/ack
//   handshake of arbitrary latency; data has priority, a starvation counter
//   forces a fetch after MAX_STARVE data grants, and an access with no ack
//   for TIMEOUT+1 cycles is aborted with bus_err.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   if_req/if_addr             fetch request, held until if_valid
//   if_rdata/if_valid/if_stall fetched word, 1-cycle completion, stall level
//   d_req/d_we/d_addr/d_wdata  load/store request, held until d_valid
//   d_rdata/d_valid/d_stall    load data, 1-cycle completion, stall level
//   bus_err                    qualifies a valid pulse of a timed-out access
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack          memory response, sampled while mem_req = 1
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_stall,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic [SW-1:0]   starve_cnt;

  logic if_elig;
  logic d_elig;
  logic grant_d;
  logic grant_f;
  logic starve_ok;
  logic timed_out;

  // A requester whose valid is high this cycle still shows the request that
  // just completed, so it must not be granted again from it.
  assign if_elig   = if_req & ~if_valid;
  assign d_elig    = d_req & ~d_valid;
  assign starve_ok = (starve_cnt < SW'(MAX_STARVE));
  assign grant_d   = d_elig & (~if_elig | starve_ok);
  assign grant_f   = if_elig & ~grant_d;
  assign timed_out = (wait_cnt == WW'(TIMEOUT));

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      bus_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            wait_cnt  <= '0;
            if (if_elig && starve_ok) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end else if (grant_f) begin
            state      <= FETCH;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            wait_cnt   <= '0;
            starve_cnt <= '0;
          end
        end

        FETCH, DATA: begin
          // An ack takes precedence over a timeout reached in the same cycle.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (state == FETCH) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              d_valid <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end else if (timed_out) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            bus_err <= 1'b1;
            if (state == FETCH) begin
              if_valid <= 1'b1;
              if_rdata <= '0;
            end else begin
              d_valid <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
